// File: rtl/inst_queue_pkg.sv
// Shared types and defaults for the fetch-to-issue instruction queue.
// Entries are {pc, inst}, with pc in the upper half.
package inst_queue_pkg;

    localparam int INST_Q_DEPTH  = 16;
    localparam int INST_Q_DATA_W = 64;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } iq_entry_t;

    // Requested pop count, clipped to what the queue actually holds.
    function automatic logic [1:0] pop_amount(
        input logic p1,
        input logic p2,
        input logic has1,
        input logic has2
    );
        if (p1 && p2 && has2)
            pop_amount = 2'd2;
        else if (p1 && has1)
            pop_amount = 2'd1;
        else
            pop_amount = 2'd0;
    endfunction

endpackage

// File: rtl/inst_queue_mem.sv
// Instruction queue storage: two write ports, two async read ports.
// Contents are deliberately not reset.
module inst_queue_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_1,
    input  logic [AW-1:0]     waddr_1,
    input  logic [DATA_W-1:0] wdata_1,
    input  logic              we_2,
    input  logic [AW-1:0]     waddr_2,
    input  logic [DATA_W-1:0] wdata_2,
    input  logic [AW-1:0]     raddr_1,
    output logic [DATA_W-1:0] rdata_1,
    input  logic [AW-1:0]     raddr_2,
    output logic [DATA_W-1:0] rdata_2
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_1)
            mem[waddr_1] <= wdata_1;
        if (we_2)
            mem[waddr_2] <= wdata_2;
    end

    assign rdata_1 = mem[raddr_1];
    assign rdata_2 = mem[raddr_2];

endmodule

// File: rtl/inst_queue.sv
// Decoupling queue between fetch and issue: up to two pushes and two
// pops per cycle, oldest two entries presented fall-through.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH  = INST_Q_DEPTH,
    parameter int DATA_W = INST_Q_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     w_ena_1,
    input  logic [DATA_W-1:0]        w_data_1,
    input  logic                     w_ena_2,
    input  logic [DATA_W-1:0]        w_data_2,
    output logic                     full,
    output logic [DATA_W-1:0]        r_data_1,
    output logic                     r_data_1_ok,
    output logic [DATA_W-1:0]        r_data_2,
    output logic                     r_data_2_ok,
    input  logic                     p_data_1,
    input  logic                     p_data_2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [1:0]        pop_n;
    logic [1:0]        push_n;
    logic              accept;
    logic              we_1;
    logic              we_2;
    logic [DATA_W-1:0] wdata_1;

    assign full        = count > CW'(DEPTH - 2);
    assign r_data_1_ok = count != '0;
    assign r_data_2_ok = count >= CW'(2);

    assign pop_n  = pop_amount(p_data_1, p_data_2,
                               r_data_1_ok, r_data_2_ok);
    assign accept = !full && !flush;

    // A lone enable always lands at tail so the queue stays packed.
    assign we_1    = accept && (w_ena_1 || w_ena_2);
    assign we_2    = accept && w_ena_1 && w_ena_2;
    assign wdata_1 = w_ena_1 ? w_data_1 : w_data_2;
    assign push_n  = {1'b0, we_1} + {1'b0, we_2};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(pop_n);
            tail  <= tail + AW'(push_n);
            count <= count + CW'(push_n) - CW'(pop_n);
        end
    end

    inst_queue_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .we_1    (we_1),
        .waddr_1 (tail),
        .wdata_1 (wdata_1),
        .we_2    (we_2),
        .waddr_2 (tail + AW'(1)),
        .wdata_2 (w_data_2),
        .raddr_1 (head),
        .rdata_1 (r_data_1),
        .raddr_2 (head + AW'(1)),
        .rdata_2 (r_data_2)
    );

    a_count_bound: assert property (
        @(posedge clk) disable iff (!rst_n) count <= CW'(DEPTH)
    );

endmodule

// File: tb/tb_inst_queue.sv
// Directed vector table plus hand sequences and a scoreboard soak
// for the dual-push / dual-pop instruction queue.
module tb_inst_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        w_ena_1;
    logic [63:0] w_data_1;
    logic        w_ena_2;
    logic [63:0] w_data_2;
    logic        full;
    logic [63:0] r_data_1;
    logic        r_data_1_ok;
    logic [63:0] r_data_2;
    logic        r_data_2_ok;
    logic        p_data_1;
    logic        p_data_2;
    logic [4:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    inst_queue #(.DEPTH(16), .DATA_W(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .w_ena_1     (w_ena_1),
        .w_data_1    (w_data_1),
        .w_ena_2     (w_ena_2),
        .w_data_2    (w_data_2),
        .full        (full),
        .r_data_1    (r_data_1),
        .r_data_1_ok (r_data_1_ok),
        .r_data_2    (r_data_2),
        .r_data_2_ok (r_data_2_ok),
        .p_data_1    (p_data_1),
        .p_data_2    (p_data_2),
        .count       (count)
    );

    typedef struct {
        logic        fl;
        logic        w1;
        logic [63:0] d1;
        logic        w2;
        logic [63:0] d2;
        logic        p1;
        logic        p2;
        int          e_cnt;
        logic        e_ok1;
        logic [63:0] e_r1;
        logic        e_ok2;
        logic [63:0] e_r2;
        logic        e_full;
    } vec_t;

    localparam logic [63:0] A = 64'h0000_1000_0000_00a1;
    localparam logic [63:0] B = 64'h0000_1004_0000_00b2;
    localparam logic [63:0] C = 64'h0000_1008_0000_00c3;
    localparam logic [63:0] D = 64'h0000_100c_0000_00d4;
    localparam logic [63:0] E = 64'h0000_1010_0000_00e5;
    localparam logic [63:0] F = 64'h0000_1014_0000_00f6;
    localparam logic [63:0] G = 64'h0000_1018_0000_0017;
    localparam logic [63:0] X = 64'h0000_2000_dead_beef;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic idle();
        flush    = 1'b0;
        w_ena_1  = 1'b0;
        w_ena_2  = 1'b0;
        w_data_1 = '0;
        w_data_2 = '0;
        p_data_1 = 1'b0;
        p_data_2 = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic push(input logic e1, input logic [63:0] d1,
                        input logic e2, input logic [63:0] d2);
        w_ena_1  = e1;
        w_data_1 = d1;
        w_ena_2  = e2;
        w_data_2 = d2;
        step();
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [63:0] fill_d(input int k);
        return {32'h0000_3000 + 32'(k * 4), 32'hf000_0000 + 32'(k)};
    endfunction

    vec_t vt[9];
    logic [63:0] q[$];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vt[0] = '{0, 1, A, 1, B, 0, 0, 2, 1, A, 1, B, 0};
        vt[1] = '{0, 0, 0, 0, 0, 1, 0, 1, 1, B, 0, 0, 0};
        vt[2] = '{0, 1, C, 1, D, 1, 0, 2, 1, C, 1, D, 0};
        vt[3] = '{0, 0, X, 1, E, 0, 0, 3, 1, C, 1, D, 0};
        vt[4] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, E, 0, 0, 0};
        vt[5] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, E, 0, 0, 0};
        vt[6] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        vt[7] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        vt[8] = '{0, 1, F, 1, G, 1, 1, 2, 1, F, 1, G, 0};

        do_reset();
        chk("reset.count", 64'(count), 64'd0);
        chk("reset.ok1", 64'(r_data_1_ok), 64'd0);
        chk("reset.ok2", 64'(r_data_2_ok), 64'd0);
        chk("reset.full", 64'(full), 64'd0);

        for (int i = 0; i < 9; i++) begin
            flush    = vt[i].fl;
            w_ena_1  = vt[i].w1;
            w_data_1 = vt[i].d1;
            w_ena_2  = vt[i].w2;
            w_data_2 = vt[i].d2;
            p_data_1 = vt[i].p1;
            p_data_2 = vt[i].p2;
            step();
            chk($sformatf("vec%0d.count", i), 64'(count), 64'(vt[i].e_cnt));
            chk($sformatf("vec%0d.ok1", i), 64'(r_data_1_ok), 64'(vt[i].e_ok1));
            chk($sformatf("vec%0d.ok2", i), 64'(r_data_2_ok), 64'(vt[i].e_ok2));
            chk($sformatf("vec%0d.full", i), 64'(full), 64'(vt[i].e_full));
            if (vt[i].e_ok1)
                chk($sformatf("vec%0d.r1", i), r_data_1, vt[i].e_r1);
            if (vt[i].e_ok2)
                chk($sformatf("vec%0d.r2", i), r_data_2, vt[i].e_r2);
        end

        // Fill to capacity, then a dropped push, then drain in order.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            push(1'b1, fill_d(2 * k), 1'b1, fill_d(2 * k + 1));
            chk("fill.count", 64'(count), 64'(2 * (k + 1)));
            chk("fill.full", 64'(full), 64'(k == 7));
        end
        push(1'b1, X, 1'b1, X);
        chk("fill.drop.count", 64'(count), 64'd16);
        chk("fill.drop.full", 64'(full), 64'd1);
        for (int j = 0; j < 8; j++) begin
            chk("drain.r1", r_data_1, fill_d(2 * j));
            chk("drain.r2", r_data_2, fill_d(2 * j + 1));
            p_data_1 = 1'b1;
            p_data_2 = 1'b1;
            step();
        end
        chk("drain.count", 64'(count), 64'd0);

        // Flush beats a simultaneous dual push and dual pop.
        push(1'b1, A, 1'b1, B);
        push(1'b1, C, 1'b1, D);
        push(1'b1, E, 1'b0, X);
        chk("pre_flush.count", 64'(count), 64'd5);
        flush    = 1'b1;
        w_ena_1  = 1'b1;
        w_data_1 = F;
        w_ena_2  = 1'b1;
        w_data_2 = G;
        p_data_1 = 1'b1;
        p_data_2 = 1'b1;
        step();
        chk("flush.count", 64'(count), 64'd0);
        chk("flush.ok1", 64'(r_data_1_ok), 64'd0);
        chk("flush.ok2", 64'(r_data_2_ok), 64'd0);
        chk("flush.full", 64'(full), 64'd0);
        push(1'b1, X, 1'b0, A);
        chk("post_flush.r1", r_data_1, X);
        chk("post_flush.count", 64'(count), 64'd1);

        // Scoreboard soak across many pointer wraps.
        do_reset();
        q.delete();
        for (int i = 0; i < 1000; i++) begin
            int m;
            int p;
            int npop;
            bit acc;
            chk("rnd.count", 64'(count), 64'(q.size()));
            chk("rnd.ok1", 64'(r_data_1_ok), 64'(q.size() != 0));
            chk("rnd.ok2", 64'(r_data_2_ok), 64'(q.size() >= 2));
            chk("rnd.full", 64'(full), 64'(q.size() > 14));
            if (q.size() >= 1)
                chk("rnd.r1", r_data_1, q[0]);
            if (q.size() >= 2)
                chk("rnd.r2", r_data_2, q[1]);
            m = $urandom_range(0, 3);
            p = $urandom_range(0, 2);
            w_ena_1  = m[0];
            w_ena_2  = m[1];
            w_data_1 = {$urandom, $urandom};
            w_data_2 = {$urandom, $urandom};
            p_data_1 = (p >= 1);
            p_data_2 = (p == 2) || (p == 0 && $urandom_range(0, 1) == 1);
            acc  = q.size() <= 14;
            npop = (p > q.size()) ? q.size() : p;
            if (acc && m[0])
                q.push_back(w_data_1);
            if (acc && m[1])
                q.push_back(w_data_2);
            for (int k = 0; k < npop; k++)
                void'(q.pop_front());
            step();
        end

        // Asynchronous reset mid-stream.
        do_reset();
        push(1'b1, A, 1'b1, B);
        push(1'b1, C, 1'b1, D);
        push(1'b1, E, 1'b1, F);
        push(1'b1, G, 1'b0, X);
        chk("pre_areset.count", 64'(count), 64'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset.count", 64'(count), 64'd0);
        chk("areset.ok1", 64'(r_data_1_ok), 64'd0);
        chk("areset.full", 64'(full), 64'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        w_ena_1  = 1'b1;
        w_data_1 = X;
        #1;
        chk("areset.nobypass", 64'(r_data_1_ok), 64'd0);
        step();
        chk("areset.first.ok1", 64'(r_data_1_ok), 64'd1);
        chk("areset.first.r1", r_data_1, X);
        chk("areset.first.count", 64'(count), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
